// File: rtl/tc_host_reader.sv
// tc_host_reader: SPI mode-0 host that reads WORD_SIZE-bit words from the
// thermocouple chip's slave port, on request or by periodic auto-polling.
// Each captured word is presented on o_wout with a one-cycle o_wstb.
module tc_host_reader #(
    parameter int WORD_SIZE   = 16,
    parameter int CLK_DIV     = 4,
    parameter int POLL_PERIOD = 10000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_auto,
    input  logic [WORD_SIZE-1:0] i_win,
    output logic                 o_sck,
    output logic                 o_sce,
    output logic                 o_sout,
    input  logic                 i_sin,
    output logic [WORD_SIZE-1:0] o_wout,
    output logic                 o_wstb,
    output logic                 o_busy
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(WORD_SIZE + 1);
    localparam int PW = $clog2(POLL_PERIOD + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_SIZE - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t               r_state;
    logic [DW-1:0]        r_div;
    logic [BW-1:0]        r_bit;
    logic [PW-1:0]        r_poll;
    logic [WORD_SIZE-1:0] r_tx;
    logic [WORD_SIZE-1:0] r_rx;
    logic                 r_sck;
    logic                 r_sce;
    logic                 r_sout;
    logic [WORD_SIZE-1:0] r_wout;
    logic                 r_wstb;
    logic                 r_busy;

    logic w_div_end;
    logic w_poll_due;
    logic w_go;

    // A phase ends when the divider has counted CLK_DIV cycles; a start is
    // only honoured in IDLE, and a request plus a due poll collapse into one.
    assign w_div_end  = (r_div == DIV_LAST);
    assign w_poll_due = i_auto && (r_poll == POLL_LAST);
    assign w_go       = (r_state == S_IDLE) && (i_start || w_poll_due);

    // Poll counter: held at 0 while auto is off, restarted on every accepted
    // transaction, otherwise counts up and saturates on the due value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_poll <= '0;
        end else if (!i_auto || w_go) begin
            r_poll <= '0;
        end else if (r_poll != POLL_LAST) begin
            r_poll <= r_poll + 1'b1;
        end
    end

    // Transaction FSM with registered SPI pins, busy flag and word strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sck   <= 1'b0;
            r_sce   <= 1'b1;
            r_sout  <= 1'b0;
            r_wout  <= '0;
            r_wstb  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_wstb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_tx    <= i_win;
                        r_sout  <= i_win[WORD_SIZE-1];
                        r_sce   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sck   <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!w_div_end) begin
                        r_div <= r_div + 1'b1;
                    end else if (r_sck) begin
                        // Last cycle of the high phase: sample MISO late so
                        // the slave's synchronized SCK has long settled, then
                        // fall and move the next MOSI bit out.
                        r_div  <= '0;
                        r_rx   <= {r_rx[WORD_SIZE-2:0], i_sin};
                        r_sck  <= 1'b0;
                        r_tx   <= {r_tx[WORD_SIZE-2:0], 1'b0};
                        r_sout <= r_tx[WORD_SIZE-2];
                    end else if (r_bit == BIT_LAST) begin
                        // Full low phase after the final fall has elapsed.
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= S_HOLD;
                    end else begin
                        r_div <= '0;
                        r_bit <= r_bit + 1'b1;
                        r_sck <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_sce   <= 1'b1;
                        r_sout  <= 1'b0;
                        r_wout  <= r_rx;
                        r_wstb  <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sce   <= 1'b1;
                    r_sck   <= 1'b0;
                    r_sout  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sck  = r_sck;
    assign o_sce  = r_sce;
    assign o_sout = r_sout;
    assign o_wout = r_wout;
    assign o_wstb = r_wstb;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_tc_host_reader.sv
// Bench for tc_host_reader: a mode-0 SPI slave model answers on MISO and
// captures MOSI; transaction timing is predicted from the cycle formulas.
module tb_tc_host_reader;

    localparam int W  = 16;
    localparam int CD = 4;
    localparam int PP = 300;
    localparam int T_STB  = 1 + CD * (2 * W + 2);
    localparam int T_IDLE = 1 + CD * (2 * W + 3);

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         auto_en;
    logic [W-1:0] win;
    logic         sck, sce, sout, sin;
    logic [W-1:0] wout;
    logic         wstb, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tc_host_reader #(.WORD_SIZE(W), .CLK_DIV(CD), .POLL_PERIOD(PP)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_auto(auto_en),
        .i_win(win), .o_sck(sck), .o_sce(sce), .o_sout(sout), .i_sin(sin),
        .o_wout(wout), .o_wstb(wstb), .o_busy(busy)
    );

    // ---------------- SPI slave model (mode 0) ----------------
    logic [W-1:0] sl_word = '0;
    logic [W-1:0] sl_lat  = '0;
    logic [W-1:0] sl_rx   = '0;
    int           sl_rises = 0;
    int           sl_idx;

    // Latch the reply word when selected; capture MOSI on every SCK rise.
    always @(posedge sck or negedge sce) begin
        if (sck) begin
            sl_rx    <= {sl_rx[W-2:0], sout};
            sl_rises <= sl_rises + 1;
        end else begin
            sl_lat   <= sl_word;
            sl_rx    <= '0;
            sl_rises <= 0;
        end
    end

    // Bit on MISO advances after each falling edge.
    always_comb begin
        sl_idx = sl_rises - (sck ? 1 : 0);
        sin = 1'b0;
        if (!sce && sl_idx >= 0 && sl_idx < W) sin = sl_lat[W-1-sl_idx];
    end

    // ---------------- pin-level monitors ----------------
    logic last_sout = 1'b0;
    logic last_sck  = 1'b0;
    int   stab = 0;
    int   setup_viol = 0;
    int   idle_sout_viol = 0;

    always @(negedge clk) begin
        last_sout <= sout;
        last_sck  <= sck;
        stab      <= (sout !== last_sout) ? 1 : stab + 1;
        if (sck && !last_sck && !((sout === last_sout) && stab >= CD))
            setup_viol <= setup_viol + 1;
        if (sce && sout !== 1'b0)
            idle_sout_viol <= idle_sout_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request-driven read; optionally pulse i_start mid-transaction.
    task automatic run_read(input logic [W-1:0] w_in, input logic [W-1:0] s_word, input bit inject);
        int t_stb = -1;
        int t_idle = -1;
        int n_stb = 0;
        int sv0;
        logic [W-1:0] got = '0;
        sv0 = setup_viol;
        @(negedge clk);
        win = w_in;
        sl_word = s_word;
        start = 1'b1;
        for (int t = 1; t <= 160; t++) begin
            @(negedge clk);
            start = inject && (t == 50);
            if (t == 1) begin
                chk("sce_low_c1", 32'(sce), 0);
                chk("busy_c1", 32'(busy), 1);
            end
            if (wstb) begin
                n_stb++;
                if (t_stb < 0) begin
                    t_stb = t;
                    got = wout;
                end
            end
            if (!busy && t_idle < 0) t_idle = t;
        end
        start = 1'b0;
        chk("wstb_cycle", t_stb, T_STB);
        chk("wstb_count", n_stb, 1);
        chk("wout_word", 32'(got), 32'(s_word));
        chk("wout_hold", 32'(wout), 32'(s_word));
        chk("busy_fall", t_idle, T_IDLE);
        chk("sck_pulses", sl_rises, W);
        chk("mosi_word", 32'(sl_rx), 32'(w_in));
        chk("mosi_setup", setup_viol - sv0, 0);
    endtask

    initial begin
        int starts[$];
        int n_stb;
        bit prev_sce;
        logic [W-1:0] aw;

        rst = 1'b1; start = 1'b0; auto_en = 1'b0; win = '0;
        repeat (3) @(negedge clk);
        chk("rst_sce", 32'(sce), 1);
        chk("rst_sck", 32'(sck), 0);
        chk("rst_sout", 32'(sout), 0);
        chk("rst_wstb", 32'(wstb), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wout", 32'(wout), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed reads: MISO pattern, MOSI pattern, temperature word.
        run_read(16'h0000, 16'hA5C3, 1'b0);
        run_read(16'h8001, 16'h5A3C, 1'b0);
        run_read(16'h0000, 16'h0190, 1'b0);
        // Start pulse while busy is dropped.
        run_read(16'h1234, 16'hBEEF, 1'b1);

        // Randomized reads, some with a mid-transaction start pulse.
        for (int i = 0; i < 6; i++)
            run_read(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

        // Auto-poll with a concurrent request at cycles 0 and 300.
        aw = W'($urandom) | 16'h0001;
        @(negedge clk);
        sl_word = aw;
        auto_en = 1'b1;
        start = 1'b1;
        prev_sce = 1'b1;
        n_stb = 0;
        for (int t = 1; t <= 1150; t++) begin
            @(negedge clk);
            start = (t == 300) || (t == 620);
            if (prev_sce && !sce) starts.push_back(t - 1);
            prev_sce = sce;
            if (wstb) begin
                n_stb++;
                chk("auto_wout", 32'(wout), 32'(aw));
            end
        end
        auto_en = 1'b0;
        start = 1'b0;
        chk("auto_nstarts", starts.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("auto_start_t", (i < starts.size()) ? starts[i] : -1, PP * i);
        chk("auto_nstb", n_stb, 4);
        repeat (5) @(negedge clk);

        // Reset during bit 7 of the shift.
        @(negedge clk);
        win = 16'hF00F;
        sl_word = 16'h7E81;
        start = 1'b1;
        for (int t = 1; t <= 62; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_sce", 32'(sce), 1);
        chk("mid_rst_sck", 32'(sck), 0);
        chk("mid_rst_sout", 32'(sout), 0);
        chk("mid_rst_wout", 32'(wout), 0);
        chk("mid_rst_wstb", 32'(wstb), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        n_stb = 0;
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            if (wstb) n_stb++;
        end
        chk("mid_rst_nostb", n_stb, 0);
        run_read(16'hC3A5, 16'h0F0F, 1'b0);

        chk("sout_idle_zero", idle_sout_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
